// File: rtl/fetch_stage_if.sv
// fetch_stage_if
//   Bundles the fetch stage's hazard/redirect inputs, the instruction
//   memory read path and the IF/ID pipeline register outputs.
//   master : the fetch stage (drives PC and the IF/ID outputs)
//   slave  : the environment (hazard unit, EX redirect, instruction memory)
//
//   STALL            hold request for PC and IF/ID
//   BRANCH_TAKEN     redirect request from EX
//   BRANCH_TARGET    redirect address from EX
//   INSTRUCTION      instruction memory word for the current PC
//   PC               fetch address
//   IFID_PC          address of the instruction held in IF/ID
//   IFID_PC4         IFID_PC + 4
//   IFID_INSTRUCTION instruction held in IF/ID
//   IFID_VALID       IF/ID holds a real instruction
//   MISALIGNED       sticky misaligned-redirect flag
interface fetch_stage_if;
  logic        STALL;
  logic        BRANCH_TAKEN;
  logic [31:0] BRANCH_TARGET;
  logic [31:0] INSTRUCTION;
  logic [31:0] PC;
  logic [31:0] IFID_PC;
  logic [31:0] IFID_PC4;
  logic [31:0] IFID_INSTRUCTION;
  logic        IFID_VALID;
  logic        MISALIGNED;

  modport master (
    input  STALL, BRANCH_TAKEN, BRANCH_TARGET, INSTRUCTION,
    output PC, IFID_PC, IFID_PC4, IFID_INSTRUCTION, IFID_VALID, MISALIGNED
  );

  modport slave (
    output STALL, BRANCH_TAKEN, BRANCH_TARGET, INSTRUCTION,
    input  PC, IFID_PC, IFID_PC4, IFID_INSTRUCTION, IFID_VALID, MISALIGNED
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction fetch stage: owns the PC, presents it to instruction memory,
//   and captures the returned word into the IF/ID pipeline register.
//   Supports hazard stalls and EX-stage redirects (which insert a bubble).
//   All outputs are registered; nothing combinational reaches the outputs.
//
//   CLK    rising-edge clock
//   RESET  synchronous active-high reset
//   bus    fetch_stage_if.master (see interface for signal list)
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic           CLK,
  input  logic           RESET,
  fetch_stage_if.master  bus
);

  localparam logic [1:0] BOOT     = 2'd0;
  localparam logic [1:0] RUN      = 2'd1;
  localparam logic [1:0] REDIRECT = 2'd2;

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc4;
  logic [31:0] ifid_instr;
  logic        ifid_valid;
  logic        misaligned;

  logic [1:0]  state_next;
  logic [31:0] pc_next;
  logic [31:0] ifid_pc_next;
  logic [31:0] ifid_pc4_next;
  logic [31:0] ifid_instr_next;
  logic        ifid_valid_next;
  logic        misaligned_next;

  logic [31:0] pc_plus4;
  logic [31:0] target_aligned;

  // Wraps naturally modulo 2^32.
  assign pc_plus4       = pc + 32'd4;
  assign target_aligned = {bus.BRANCH_TARGET[31:2], 2'b00};

  // Next-state and next-register computation for the fetch FSM.
  always_comb begin
    state_next      = state;
    pc_next         = pc;
    ifid_pc_next    = ifid_pc;
    ifid_pc4_next   = ifid_pc4;
    ifid_instr_next = ifid_instr;
    ifid_valid_next = ifid_valid;
    misaligned_next = misaligned;

    case (state)
      // First edge after reset always fetches RESET_PC; hazards are ignored
      // because nothing is in flight yet.
      BOOT: begin
        ifid_pc_next    = pc;
        ifid_pc4_next   = pc_plus4;
        ifid_instr_next = bus.INSTRUCTION;
        ifid_valid_next = 1'b1;
        pc_next         = pc_plus4;
        state_next      = RUN;
      end

      // REDIRECT differs from RUN only in that IF/ID still holds the bubble;
      // the transition rules are the same, so both share one branch.
      RUN, REDIRECT: begin
        if (bus.BRANCH_TAKEN) begin
          // Redirect wins over stall; IFID_PC/IFID_PC4 keep the old values.
          pc_next         = target_aligned;
          ifid_instr_next = NOP_INSTR;
          ifid_valid_next = 1'b0;
          state_next      = REDIRECT;
          if (bus.BRANCH_TARGET[1:0] != 2'b00) begin
            misaligned_next = 1'b1;
          end else begin
            misaligned_next = misaligned;
          end
        end else if (!bus.STALL) begin
          ifid_pc_next    = pc;
          ifid_pc4_next   = pc_plus4;
          ifid_instr_next = bus.INSTRUCTION;
          ifid_valid_next = 1'b1;
          pc_next         = pc_plus4;
          state_next      = RUN;
        end else begin
          state_next = state;
        end
      end

      // Unreachable encoding: recover to the reset condition.
      default: begin
        state_next      = BOOT;
        pc_next         = RESET_PC;
        ifid_pc_next    = 32'h0000_0000;
        ifid_pc4_next   = 32'h0000_0000;
        ifid_instr_next = NOP_INSTR;
        ifid_valid_next = 1'b0;
        misaligned_next = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= BOOT;
      pc         <= RESET_PC;
      ifid_pc    <= 32'h0000_0000;
      ifid_pc4   <= 32'h0000_0000;
      ifid_instr <= NOP_INSTR;
      ifid_valid <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      state      <= state_next;
      pc         <= pc_next;
      ifid_pc    <= ifid_pc_next;
      ifid_pc4   <= ifid_pc4_next;
      ifid_instr <= ifid_instr_next;
      ifid_valid <= ifid_valid_next;
      misaligned <= misaligned_next;
    end
  end

  assign bus.PC               = pc;
  assign bus.IFID_PC          = ifid_pc;
  assign bus.IFID_PC4         = ifid_pc4;
  assign bus.IFID_INSTRUCTION = ifid_instr;
  assign bus.IFID_VALID       = ifid_valid;
  assign bus.MISALIGNED       = misaligned;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage
//   Directed plus randomized bench for fetch_stage. A behavioural model
//   predicts the PC and IF/ID contents after every edge; a second instance
//   with RESET_PC = 32'hFFFFFFFC exercises address wrap-around.
module tb_fetch_stage;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] WRAP = 32'hFFFF_FFFC;

  logic CLK;
  logic RESET;

  fetch_stage_if bus ();
  fetch_stage_if wbus ();

  fetch_stage dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  fetch_stage #(.RESET_PC(WRAP)) dut_wrap (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (wbus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Model state
  logic [31:0] m_pc, m_ifid_pc, m_ifid_pc4, m_instr;
  logic        m_valid, m_mis, m_boot;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Instruction memory contents: word i = 0x00500093 + i*0x00500080
  function automatic logic [31:0] imem(input logic [31:0] a);
    return 32'h0050_0093 + (a >> 2) * 32'h0050_0080;
  endfunction

  assign bus.INSTRUCTION   = imem(bus.PC);
  assign wbus.INSTRUCTION  = imem(wbus.PC);
  assign wbus.STALL        = 1'b0;
  assign wbus.BRANCH_TAKEN = 1'b0;
  assign wbus.BRANCH_TARGET = 32'h0000_0000;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Fetch one word into the model's IF/ID and advance the model PC.
  task automatic model_fetch();
    m_ifid_pc  = m_pc;
    m_ifid_pc4 = m_pc + 32'd4;
    m_instr    = imem(m_pc);
    m_valid    = 1'b1;
    m_pc       = m_pc + 32'd4;
  endtask

  task automatic model_edge(input logic rst, input logic stall, input logic br,
                            input logic [31:0] tgt);
    if (rst) begin
      m_pc = 32'h0; m_ifid_pc = 32'h0; m_ifid_pc4 = 32'h0;
      m_instr = NOP; m_valid = 1'b0; m_mis = 1'b0; m_boot = 1'b1;
    end else if (m_boot) begin
      model_fetch();
      m_boot = 1'b0;
    end else if (br) begin
      m_pc    = tgt & 32'hFFFF_FFFC;
      m_instr = NOP;
      m_valid = 1'b0;
      if (tgt[1:0] != 2'b00) m_mis = 1'b1;
    end else if (!stall) begin
      model_fetch();
    end
  endtask

  task automatic check_all();
    check("pc",         bus.PC,               m_pc);
    check("pc_align",   {30'd0, bus.PC[1:0]}, 32'h0);
    check("ifid_pc",    bus.IFID_PC,          m_ifid_pc);
    check("ifid_pc4",   bus.IFID_PC4,         m_ifid_pc4);
    check("ifid_instr", bus.IFID_INSTRUCTION, m_instr);
    check("ifid_valid", {31'd0, bus.IFID_VALID}, {31'd0, m_valid});
    check("misaligned", {31'd0, bus.MISALIGNED}, {31'd0, m_mis});
  endtask

  // Drive one cycle of inputs, step the model across the edge, then compare.
  task automatic cycle(input logic rst, input logic stall, input logic br,
                       input logic [31:0] tgt);
    RESET             = rst;
    bus.STALL         = stall;
    bus.BRANCH_TAKEN  = br;
    bus.BRANCH_TARGET = tgt;
    @(posedge CLK);
    model_edge(rst, stall, br, tgt);
    #1;
    check_all();
  endtask

  initial begin
    m_boot = 1'b1; m_mis = 1'b0; m_valid = 1'b0;
    m_pc = 32'h0; m_ifid_pc = 32'h0; m_ifid_pc4 = 32'h0; m_instr = NOP;

    // Reset, with a branch request that reset must override
    cycle(1'b1, 1'b0, 1'b1, 32'h0000_0080);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("rst_instr", bus.IFID_INSTRUCTION, NOP);
    check("rst_pc", bus.PC, 32'h0);
    check("wrap_rst_pc", wbus.PC, WRAP);

    // Boot: stall/branch ignored, first valid entry after one edge
    cycle(1'b0, 1'b1, 1'b1, 32'h0000_0100);
    check("boot_pc", bus.PC, 32'h4);
    check("boot_instr", bus.IFID_INSTRUCTION, 32'h0050_0093);
    check("wrap_pc", wbus.PC, 32'h0);
    check("wrap_ifid_pc", wbus.IFID_PC, WRAP);
    check("wrap_ifid_pc4", wbus.IFID_PC4, 32'h0);

    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    check("seq_instr", bus.IFID_INSTRUCTION, 32'h00A0_0113);
    check("seq_pc", bus.PC, 32'h8);

    // Stall three cycles at PC=8
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 32'h0);
      check("stall_pc", bus.PC, 32'h8);
      check("stall_ifid_pc", bus.IFID_PC, 32'h4);
    end
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    check("resume_ifid_pc", bus.IFID_PC, 32'h8);

    // Branch to 0x40 at PC=12
    cycle(1'b0, 1'b0, 1'b1, 32'h0000_0040);
    check("br_pc", bus.PC, 32'h40);
    check("br_valid", {31'd0, bus.IFID_VALID}, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    check("br_ifid_pc", bus.IFID_PC, 32'h40);

    // Branch and stall together, then stall held
    cycle(1'b0, 1'b1, 1'b1, 32'h0000_0020);
    check("brst_pc", bus.PC, 32'h20);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    check("brst_hold_valid", {31'd0, bus.IFID_VALID}, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    check("brst_ifid_pc", bus.IFID_PC, 32'h20);

    // Misaligned target
    cycle(1'b0, 1'b0, 1'b1, 32'h0000_0042);
    check("mis_pc", bus.PC, 32'h40);
    check("mis_flag", {31'd0, bus.MISALIGNED}, 32'h1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0);
    check("mis_sticky", {31'd0, bus.MISALIGNED}, 32'h1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 49) == 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 6) == 0),
            $urandom);
    end

    // Reset while in the redirect bubble
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 1'b1, 32'h0000_0203);
    cycle(1'b1, 1'b1, 1'b1, 32'h0000_0300);
    check("midrst_pc", bus.PC, 32'h0);
    check("midrst_ifid_pc4", bus.IFID_PC4, 32'h0);
    check("midrst_instr", bus.IFID_INSTRUCTION, NOP);
    check("midrst_mis", {31'd0, bus.MISALIGNED}, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    check("post_rst_pc", bus.PC, 32'h4);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, address of the first fetched instruction after reset.
REQ-002 Parameter NOP_INSTR, default 32'h00000013, encoding inserted into IF/ID on reset and flush (addi x0,x0,0).
REQ-003 One clock; reset is synchronous and active-high, ports named CLK and RESET.
REQ-004 CLK  input  1  rising-edge clock for all state.
REQ-005 RESET  input  1  synchronous active-high reset.
REQ-006 STALL  input  1  hazard-unit hold request for PC and IF/ID.
REQ-007 BRANCH_TAKEN  input  1  redirect request from EX stage.
REQ-008 BRANCH_TARGET  input  32  redirect address from EX stage.
REQ-009 INSTRUCTION  input  32  word returned by instruction_memory for the current PC, same cycle.
REQ-010 PC  output  32  fetch address driven to instruction_memory.
REQ-011 IFID_PC  output  32  address of the instruction held in IF/ID.
REQ-012 IFID_PC4  output  32  IFID_PC + 4, for link writeback.
REQ-013 IFID_INSTRUCTION  output  32  instruction held in IF/ID.
REQ-014 IFID_VALID  output  1  IF/ID holds a real instruction, not a bubble.
REQ-015 MISALIGNED  output  1  sticky flag: a redirect target had bits [1:0] nonzero.

Function
REQ-016 State updates only on the rising CLK edge; all outputs are registered.
REQ-017 Internal FSM states: BOOT, RUN, REDIRECT.
REQ-018 BOOT: entered on reset; next edge with RESET low captures INSTRUCTION at RESET_PC into IF/ID, PC <= RESET_PC+4, goes to RUN; BRANCH_TAKEN and STALL are ignored in BOOT.
REQ-019 RUN, no STALL, no BRANCH_TAKEN: IFID_PC <= PC, IFID_PC4 <= PC+4, IFID_INSTRUCTION <= INSTRUCTION, IFID_VALID <= 1, PC <= PC+4.
REQ-020 RUN, STALL high, BRANCH_TAKEN low: PC and all IFID_* hold their values.
REQ-021 BRANCH_TAKEN high has priority over STALL: PC <= {BRANCH_TARGET[31:2],2'b00}, IFID_INSTRUCTION <= NOP_INSTR, IFID_VALID <= 0, IFID_PC/IFID_PC4 hold, FSM -> REDIRECT.
REQ-022 REDIRECT: one bubble cycle; if STALL low, IF/ID captures the instruction at the new PC per REQ-019 and FSM -> RUN; if STALL high, hold and remain in REDIRECT; a further BRANCH_TAKEN re-applies REQ-021.
REQ-023 MISALIGNED set to 1 on any accepted redirect with BRANCH_TARGET[1:0] != 0; cleared only by RESET.
REQ-024 PC arithmetic is modulo 2^32: PC 32'hFFFFFFFC increments to 32'h00000000, IFID_PC4 likewise wraps.
REQ-025 PC[1:0] is always 2'b00.
REQ-026 Combinational paths from STALL/BRANCH_TAKEN to any output are prohibited.

Reset
REQ-027 RESET high at an edge: PC <= RESET_PC, IFID_PC <= 0, IFID_PC4 <= 0, IFID_INSTRUCTION <= NOP_INSTR, IFID_VALID <= 0, MISALIGNED <= 0, FSM <= BOOT.
REQ-028 RESET overrides STALL and BRANCH_TAKEN in the same cycle, including mid-redirect.
REQ-029 After reset release, first valid IF/ID entry appears after exactly one rising edge.

Verification
REQ-030 Sequential fetch: reset, release, memory words 0x00500093,0x00A00113,... -> IFID_PC 0,4,8,12 on successive edges, IFID_VALID 1, PC leading by 4.
REQ-031 Stall: STALL high for 3 cycles at PC=8 -> PC stays 8, IFID_PC stays 4, resumes with IFID_PC=8 after release.
REQ-032 Branch: BRANCH_TAKEN with target 0x40 while PC=12 -> next edge PC=0x40, IFID_INSTRUCTION=0x00000013, IFID_VALID=0; following edge IFID_PC=0x40, valid 1.
REQ-033 Branch+stall same cycle: both high, target 0x20 -> redirect taken, PC=0x20; bubble held while STALL stays high.
REQ-034 Misaligned/wrap: target 0x42 -> PC=0x40, MISALIGNED=1 until RESET; RESET_PC=32'hFFFFFFFC -> second PC=0, IFID_PC4=0.
REQ-035 Reset mid-operation: RESET asserted during REDIRECT -> all outputs at REQ-027 values on that edge.
